// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - instruction field widths, positions and word encoder shared with the CPU decoder
package cpu_isa_pkg;
   localparam int OPCODE_W   = 3;
   localparam int RD_W       = 2;
   localparam int SRC_W      = 3;
   localparam int INSTR_W    = 8;
   localparam int OPCODE_LSB = 5;
   localparam int RD_LSB     = 3;
   localparam int SRC_LSB    = 0;
   localparam int IMM_MAX    = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } wr_state_t;

   function automatic logic [INSTR_W-1:0] encode_instr(
      input logic [OPCODE_W-1:0] opcode,
      input logic [RD_W-1:0]     rd,
      input logic [SRC_W-1:0]    field
   );
      logic [INSTR_W-1:0] word;
      word = '0;
      word[OPCODE_LSB +: OPCODE_W] = opcode;
      word[RD_LSB +: RD_W]         = rd;
      word[SRC_LSB +: SRC_W]       = field;
      return word;
   endfunction
endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO with push/pop/count and a synchronous flush
module instr_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // a push into a full FIFO is only taken when the head leaves in the same cycle
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count < (PTR_W+1)'(DEPTH)) || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction field tuples and streams them into instruction memory from address 0
module instr_encoder
   import cpu_isa_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OPCODE_W-1:0]   in_opcode,
   input  logic [RD_W-1:0]       in_rd,
   input  logic [SRC_W-1:0]      in_src,
   input  logic [7:0]            in_imm,
   input  logic                  in_use_imm,
   output logic                  mem_we,
   input  logic                  mem_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [INSTR_W-1:0]    mem_wdata,
   output logic [ADDR_W:0]       wr_count,
   output logic                  prog_full,
   output logic                  err_imm
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int SUM_W = (ADDR_W + 2 > CNT_W + 1) ? ADDR_W + 2 : CNT_W + 1;
   localparam logic [SUM_W-1:0]  CAPACITY = SUM_W'(1) << ADDR_W;
   localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'((1 << ADDR_W) - 1);

   wr_state_t            state;
   wr_state_t            next_state;
   logic [CNT_W-1:0]     fifo_count;
   logic [INSTR_W-1:0]   fifo_head;
   logic [INSTR_W-1:0]   word;
   logic [SUM_W-1:0]     committed;
   logic                 accept;
   logic                 imm_bad;
   logic                 push;
   logic                 pop;

   // words already written plus words still buffered must never exceed memory capacity
   assign committed = SUM_W'(wr_count) + SUM_W'(fifo_count);
   assign in_ready  = !clear && (fifo_count < CNT_W'(FIFO_DEPTH)) && (committed < CAPACITY);
   assign accept    = in_valid && in_ready;
   assign imm_bad   = in_use_imm && (in_imm > 8'(IMM_MAX));
   assign push      = accept && !imm_bad;
   assign pop       = mem_we && mem_ready && !clear;
   assign word      = encode_instr(in_opcode, in_rd, in_use_imm ? in_imm[SRC_W-1:0] : in_src);
   assign mem_addr  = wr_count[ADDR_W-1:0];
   assign mem_wdata = mem_we ? fifo_head : '0;

   instr_fifo #(.WIDTH(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (word),
      .rdata (fifo_head),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (clear) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (push || fifo_count != '0) next_state = ST_WRITE;
            ST_WRITE: begin
               if (pop && wr_count == LAST_IDX)                       next_state = ST_FULL;
               else if (pop && fifo_count == CNT_W'(1) && !push)      next_state = ST_IDLE;
            end
            ST_FULL:  next_state = ST_FULL;
            default:  next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_we    = (state == ST_WRITE);
      prog_full = (state == ST_FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count <= '0;
         err_imm  <= 1'b0;
      end else if (clear) begin
         wr_count <= '0;
         err_imm  <= 1'b0;
      end else begin
         if (pop)               wr_count <= wr_count + (ADDR_W+1)'(1);
         if (accept && imm_bad) err_imm  <= 1'b1;
      end
   end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs CPU instruction fields into 8-bit instruction words and streams them into instruction memory, starting at address 0. It is the write-side counterpart of the CPU's instruction field decoder. It sits between the test or boot loader and the instruction memory write port. Field tuples are accepted on a valid/ready handshake, encoded, buffered in a small FIFO, and written with a self-incrementing address.

## Interface
- `ADDR_W`, default 4: instruction memory address width; capacity is 2^ADDR_W words.
- `FIFO_DEPTH`, default 4: encoded-word buffer depth, power of two, at least 2.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `clear` in 1: synchronous flush; empties the FIFO, zeroes the address, clears `err_imm`.
- `in_valid` in 1: field tuple valid.
- `in_ready` out 1: block can accept a tuple.
- `in_opcode` in 3: operation code.
- `in_rd` in 2: destination register.
- `in_src` in 3: source register, used when `in_use_imm`=0.
- `in_imm` in 8: immediate, used when `in_use_imm`=1.
- `in_use_imm` in 1: select immediate instead of source register.
- `mem_we` out 1: write strobe.
- `mem_ready` in 1: memory accepts a write this cycle.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out 8: encoded instruction word.
- `wr_count` out ADDR_W+1: number of words written since reset or clear.
- `prog_full` out 1: all 2^ADDR_W words written.
- `err_imm` out 1: sticky flag, set when an immediate was out of range.

## Operation
- Encoding: word = {opcode[2:0], rd[1:0], field[2:0]}.
  - Bits [7:5] are the opcode, [4:3] are rd, [2:0] are the source or immediate field.
  - field = `in_use_imm` ? `in_imm[2:0]` : `in_src`.
- Immediate range: if `in_use_imm`=1 and `in_imm` > 7:
  - the tuple is consumed (handshake completes);
  - nothing is enqueued;
  - `err_imm` is set.
- Accept: an accept occurs when `in_valid` and `in_ready` are both high.
- `in_ready` = !clear && fifo_count < FIFO_DEPTH && (wr_count + fifo_count) < 2^ADDR_W.
  - This guarantees that no accepted word is ever dropped.
- Writer FSM:
  - IDLE: FIFO empty, `mem_we`=0.
  - IDLE -> WRITE when the FIFO is non-empty.
  - WRITE: `mem_we`=1, with `mem_wdata` = FIFO head and `mem_addr` = current address.
    - On `mem_we` && `mem_ready`: pop the FIFO, increment the address and `wr_count`.
  - WRITE -> IDLE when the last entry pops and there is no push in the same cycle.
  - WRITE -> FULL when `wr_count` reaches 2^ADDR_W.
  - FULL: `mem_we`=0, `prog_full`=1, `in_ready`=0. Only `clear` or reset leaves FULL, going to IDLE.
- `mem_wdata` and `mem_addr` hold stable while `mem_we`=1 and `mem_ready`=0.
- Simultaneous push and pop with the FIFO full is legal; the count is unchanged.
- `clear` overrides everything in the same cycle:
  - no accept, no pop;
  - next state is IDLE with the address at 0.
- Words are written in acceptance order, with no reordering.

## Timing
- Reset values: `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `wr_count`=0, `prog_full`=0, `err_imm`=0, FSM in IDLE, FIFO empty.
  - `rst_n` low mid-write drops the word immediately; nothing is retained.
- Latency: a tuple accepted in cycle N makes `mem_we` high in cycle N+1 at the earliest.
- Throughput: one word per cycle while `mem_ready`=1 is held.
- `err_imm`:
  - rises in the cycle after the offending accept;
  - stays high until `clear` or reset.
- `prog_full`: rises in the cycle after the 2^ADDR_W-th write handshake.
- `in_ready`: a registered/combinational mix is permitted, but it must never depend combinationally on `in_valid`.

## Structure
- Shared package `cpu_isa_pkg` holds:
  - widths: OPCODE_W=3, RD_W=2, SRC_W=3, INSTR_W=8;
  - field LSB positions: OPCODE_LSB=5, RD_LSB=3, SRC_LSB=0;
  - IMM_MAX=7.
- The CPU decoder uses the same constants.
- One sub-module, `instr_fifo`: synchronous FIFO parameterised by width and depth, with push/pop/count/clear.
- The encode logic and the writer FSM stay in `instr_encoder`.

## Test plan
- Register form: opcode=3'b010, rd=2'b01, src=3'b110, use_imm=0, `mem_ready`=1. Required: `mem_we`=1 next cycle with `mem_addr`=0 and `mem_wdata`=8'h4E; `wr_count`=1 afterwards.
- Immediate form: opcode=3'b101, rd=2'b11, imm=8'd5, use_imm=1. Required: `mem_wdata`=8'hBD. Then imm=8'd9. Required: handshake completes, no write, address unchanged, `err_imm`=1 until `clear`.
- Backpressure: `mem_ready`=0 while pushing 6 tuples back-to-back. Required:
  - `in_ready` drops after 4 accepts;
  - `mem_addr`/`mem_wdata` stay stable;
  - after `mem_ready`=1, words appear in order at addresses 0..5 at one per cycle.
- Fill: push 20 tuples with `mem_ready`=1. Required:
  - exactly 16 writes, at addresses 0..15;
  - `in_ready` low once 16 words are committed;
  - `prog_full`=1 and `wr_count`=16.
  - Then pulse `clear`. Required: `prog_full`=0, `mem_addr`=0, `in_ready`=1.
- Clear/reset mid-operation: with 3 words queued and `mem_ready`=0, assert `clear` in the same cycle as `in_valid`. Required: no accept and an empty FIFO next cycle. Repeat with `rst_n` low. Required: all outputs at their reset values immediately.
